// File: rtl/riscv_cache_flush_ctrl.sv
// riscv_cache_flush_ctrl: walks every set/way of the cache tag array.
// Clean lines are invalidated. In flush mode, dirty lines are written back
// through the eviction handshake before they are invalidated.
// The tag/lookup pipeline is stalled for the whole walk and receives a
// one-cycle flush at the start.
// Optional feature: define RV_CACHE_FLUSH_STATS_EN to enable a saturating
// count of evictions on evict_cnt_o. Without it, evict_cnt_o is tied to 0.
module riscv_cache_flush_ctrl #(
  parameter int PLEN         = 32,
  parameter int IDX_BITS     = 7,
  parameter int BLK_OFF_BITS = 5,
  parameter int WAYS         = 2,
  localparam int TAG_BITS    = PLEN - IDX_BITS - BLK_OFF_BITS,
  localparam int WAY_BITS    = (WAYS > 2) ? $clog2(WAYS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                invalidate_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                stall_o,
  output logic                pipe_flush_o,
  output logic                tag_re_o,
  output logic [IDX_BITS-1:0] tag_idx_o,
  output logic [WAY_BITS-1:0] tag_way_o,
  input  logic                tag_valid_i,
  input  logic                tag_dirty_i,
  input  logic [TAG_BITS-1:0] tag_i,
  output logic                inv_we_o,
  output logic                evict_req_o,
  output logic [PLEN-1:0]     evict_adr_o,
  input  logic                evict_ack_i,
  output logic [15:0]         evict_cnt_o
);

  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_EVICT, S_INV, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q;
  logic [WAY_BITS-1:0]   way_q;
  logic                  mode_q;
  logic [PLEN-1:0]       adr_q;
  logic                  pflush_q;

  logic accept, evict_go, way_last, line_last;

  assign accept    = (state_q == S_IDLE) && (invalidate_i || flush_i);
  assign evict_go  = mode_q && tag_valid_i && tag_dirty_i;
  assign way_last  = (way_q == LAST_WAY);
  assign line_last = way_last && (idx_q == LAST_IDX);

  // State register; reset aborts any walk in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the walk.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (invalidate_i || flush_i) state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: state_d = evict_go ? S_EVICT : S_INV;
      S_EVICT: if (evict_ack_i) state_d = S_INV;
      S_INV:   state_d = line_last ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Walk position, mode, eviction address and the start-of-walk pipe flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      way_q    <= '0;
      mode_q   <= 1'b0;
      adr_q    <= '0;
      pflush_q <= 1'b0;
    end else begin
      pflush_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            mode_q   <= flush_i;   // flush wins when both are requested
            idx_q    <= '0;
            way_q    <= '0;
            pflush_q <= 1'b1;      // lands exactly on the first READ cycle
          end
        end
        S_CHECK: begin
          if (evict_go) adr_q <= {tag_i, idx_q, {BLK_OFF_BITS{1'b0}}};
        end
        S_INV: begin
          // Counters stay on the last line rather than wrapping.
          if (!line_last) begin
            if (way_last) begin
              way_q <= '0;
              idx_q <= idx_q + 1'b1;
            end else begin
              way_q <= way_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded strobes; one state each, so they are mutually exclusive.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    stall_o      = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
    tag_re_o     = (state_q == S_READ);
    inv_we_o     = (state_q == S_INV);
    evict_req_o  = (state_q == S_EVICT);
    pipe_flush_o = pflush_q;
    tag_idx_o    = idx_q;
    tag_way_o    = way_q;
    evict_adr_o  = adr_q;
  end

`ifdef RV_CACHE_FLUSH_STATS_EN
  logic [15:0] cnt_q;

  // Saturating count of completed writebacks, cleared when a walk is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (accept)
      cnt_q <= '0;
    else if ((state_q == S_EVICT) && evict_ack_i && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign evict_cnt_o = cnt_q;
`else
  assign evict_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_riscv_cache_flush_ctrl.sv
// Testbench for riscv_cache_flush_ctrl with 4 sets x 2 ways.
// A small tag-array model answers the tag reads. A scoreboard queue holds
// the expected READ/EVICT/INV operations, and a per-walk vector table
// supplies the expected cycle counts.
module tb_riscv_cache_flush_ctrl;
  localparam int PLEN = 32, IDX_BITS = 2, BLK_OFF_BITS = 5, WAYS = 2;
  localparam int TAG_BITS = PLEN - IDX_BITS - BLK_OFF_BITS;

  logic clk = 0, rst = 1;
  logic invalidate_i = 0, flush_i = 0;
  logic busy_o, done_o, stall_o, pipe_flush_o, tag_re_o, inv_we_o, evict_req_o;
  logic [IDX_BITS-1:0] tag_idx_o;
  logic [0:0] tag_way_o;
  logic tag_valid_i = 0, tag_dirty_i = 0;
  logic [TAG_BITS-1:0] tag_i = '0;
  logic [PLEN-1:0] evict_adr_o;
  logic evict_ack_i;
  logic [15:0] evict_cnt_o;

  riscv_cache_flush_ctrl #(.PLEN(PLEN), .IDX_BITS(IDX_BITS),
    .BLK_OFF_BITS(BLK_OFF_BITS), .WAYS(WAYS)) dut (
    .clk_i(clk), .rst_i(rst), .invalidate_i(invalidate_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o), .pipe_flush_o(pipe_flush_o),
    .tag_re_o(tag_re_o), .tag_idx_o(tag_idx_o), .tag_way_o(tag_way_o),
    .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i), .tag_i(tag_i),
    .inv_we_o(inv_we_o), .evict_req_o(evict_req_o), .evict_adr_o(evict_adr_o),
    .evict_ack_i(evict_ack_i), .evict_cnt_o(evict_cnt_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Tag-array model: data returned the cycle after tag_re_o.
  logic [7:0] mem_v, mem_d;
  logic [TAG_BITS-1:0] mem_t [8];
  always @(posedge clk) begin
    if (tag_re_o) begin
      tag_valid_i <= mem_v[{tag_idx_o, tag_way_o}];
      tag_dirty_i <= mem_d[{tag_idx_o, tag_way_o}];
      tag_i       <= mem_t[{tag_idx_o, tag_way_o}];
    end
  end

  // Writeback responder: ack after ack_dly extra cycles of request.
  int ack_dly = 0, wcnt = 0;
  assign evict_ack_i = evict_req_o && (wcnt == ack_dly);
  always @(posedge clk) begin
    if (evict_req_o && !evict_ack_i) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  // Scoreboard of expected strobes: kind 0=read, 1=evict, 2=inv.
  typedef struct { int kind; int idx; int way; logic [PLEN-1:0] adr; } op_t;
  op_t sb[$];
  bit mon_en = 1;
  int busy_cnt, done_cnt, done_at, pf_cnt, pf_at, ev_seen;
  logic prev_req = 0;
  logic [PLEN-1:0] held_adr;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_at = busy_cnt; end
      if (pipe_flush_o) begin pf_cnt++; pf_at = busy_cnt; end
      if (busy_o) begin
        chk("strobe_excl", 64'($countones({tag_re_o, inv_we_o, evict_req_o}) <= 1), 64'd1);
        chk("stall_eq_busy", 64'(stall_o), 64'(busy_o));
      end
      if (tag_re_o || inv_we_o || (evict_req_o && !prev_req)) begin
        int k;
        k = tag_re_o ? 0 : (evict_req_o ? 1 : 2);
        if (sb.size() == 0) chk("sb_underflow", 64'(k), 64'hFF);
        else begin
          op_t e;
          e = sb.pop_front();
          chk("op_kind_idx_way", {32'(k), 16'(tag_idx_o), 16'(tag_way_o)},
              {32'(e.kind), 16'(e.idx), 16'(e.way)});
          if (k == 1) begin
            ev_seen++;
            chk("evict_adr", 64'(evict_adr_o), 64'(e.adr));
            held_adr = evict_adr_o;
          end
        end
      end else if (evict_req_o && prev_req) begin
        chk("evict_adr_stable", 64'(evict_adr_o), 64'(held_adr));
      end
      prev_req = evict_req_o;
    end else begin
      prev_req = 0;
    end
  end

  typedef struct {
    logic inv; logic flush; logic [7:0] vm; logic [7:0] dm;
    int dly; bit mid; int exp_cyc; int exp_ev; int exp_cnt;
  } vec_t;

  task automatic load_mem(input logic [7:0] vm, input logic [7:0] dm);
    mem_v = vm; mem_d = dm;
    for (int l = 0; l < 8; l++) mem_t[l] = TAG_BITS'(32'h1000 + l);
    mem_t[3] = TAG_BITS'(32'h1234);
  endtask

  task automatic run_walk(input vec_t v, input string nm);
    int n;
    load_mem(v.vm, v.dm);
    ack_dly = v.dly;
    for (int l = 0; l < 8; l++) begin
      sb.push_back('{0, l / 2, l % 2, '0});
      if (v.flush && v.vm[l] && v.dm[l])
        sb.push_back('{1, l / 2, l % 2, {mem_t[l], 2'(l / 2), 5'd0}});
      sb.push_back('{2, l / 2, l % 2, '0});
    end
    busy_cnt = 0; done_cnt = 0; done_at = -1; pf_cnt = 0; pf_at = -1; ev_seen = 0;
    @(posedge clk); #1 invalidate_i = v.inv; flush_i = v.flush;
    @(posedge clk); #1 invalidate_i = 0; flush_i = 0;
    n = 0;
    while (busy_o && n < 400) begin
      @(posedge clk); #1;
      n++;
      invalidate_i = v.mid && (n == 10);
    end
    invalidate_i = 0;
    chk({nm, "_timeout"}, 64'(n < 400), 64'd1);
    chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_cyc));
    chk({nm, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({nm, "_done_at"}, 64'(done_at), 64'(v.exp_cyc));
    chk({nm, "_pflush"}, {32'(pf_cnt), 32'(pf_at)}, {32'd1, 32'd1});
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({nm, "_evictions"}, 64'(ev_seen), 64'(v.exp_ev));
`ifdef RV_CACHE_FLUSH_STATS_EN
    chk({nm, "_evict_cnt"}, 64'(evict_cnt_o), 64'(v.exp_cnt));
`else
    chk({nm, "_evict_cnt"}, 64'(evict_cnt_o), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1 chk({nm, "_stays_idle"}, 64'(busy_o), 64'd0);
    sb.delete();
  endtask

  vec_t vt [7];

  initial begin
    int n;
    //        inv flush vm     dm     dly mid cyc ev cnt
    vt[0] = '{1, 0, 8'hFF, 8'hFF, 1, 0, 25, 0, 0};  // invalidate only
    vt[1] = '{0, 1, 8'h48, 8'h08, 2, 0, 28, 1, 1};  // (1,1) dirty, (3,0) clean
    vt[2] = '{1, 1, 8'h81, 8'h81, 1, 1, 29, 2, 2};  // both requests + mid pulse
    vt[3] = '{0, 1, 8'h10, 8'h10, 0, 0, 26, 1, 1};  // same-cycle ack
    vt[4] = '{0, 1, 8'hFF, 8'hFF, 0, 0, 33, 8, 8};  // all dirty
    vt[5] = '{1, 0, 8'hFF, 8'hFF, 0, 0, 25, 0, 0};  // counter cleared on accept
    vt[6] = '{0, 1, 8'h0F, 8'h00, 0, 0, 25, 0, 0};  // flush, nothing dirty

    load_mem(8'h00, 8'h00);
    #1;
    chk("reset_strobes", {busy_o, stall_o, done_o, pipe_flush_o, tag_re_o, inv_we_o, evict_req_o}, '0);
    chk("reset_regs", {tag_idx_o, tag_way_o, evict_adr_o, evict_cnt_o}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 7; i++) run_walk(vt[i], $sformatf("vec%0d", i));

    // Reset asserted while waiting on a writeback ack.
    mon_en = 0;
    load_mem(8'h02, 8'h02);
    ack_dly = 1000;
    @(posedge clk); #1 flush_i = 1;
    @(posedge clk); #1 flush_i = 0;
    n = 0;
    while (!evict_req_o && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_mid_evict_reached", 64'(evict_req_o), 64'd1);
    rst = 1;
    #1;
    chk("rst_mid_strobes", {busy_o, stall_o, done_o, pipe_flush_o, tag_re_o, inv_we_o, evict_req_o}, '0);
    chk("rst_mid_regs", {tag_idx_o, tag_way_o, evict_adr_o, evict_cnt_o}, '0);
    @(posedge clk); #1 rst = 0;
    done_cnt = 0;
    mon_en = 1;
    repeat (3) @(posedge clk);
    #1 chk("rst_mid_no_restart", {busy_o, 32'(done_cnt)}, '0);
    run_walk(vt[3], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end
endmodule
